localbus_dma: RTL and testbench

Word-copy DMA initiator for the LocalBus. It is the master-side counterpart of the address decoder: the decoder routes CPU cycles to RAM, GPIO and VGA, and this block drives the same addr/qin/we/qout cycles itself. The CPU programs it through a register slave port in a decoder-selected region. After arbitration it copies LEN words from SRC to DST, for example RAM to VRAM.

---
 rtl/localbus_dma.sv | 176 +++++++++++++++++
 tb/tb_localbus_dma.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/localbus_dma.sv
// localbus_dma: word-copy DMA initiator for the LocalBus.
// CPU-programmed SRC/DST/LEN/CTRL registers; copies LEN words from SRC to DST
// as a bus master after arbitration, with abort/resume and a level interrupt.
module localbus_dma #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LENW    = 16,
    parameter logic [2:0]  WE_WORD = 3'b011
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sel,
    input  logic [3:0]      addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      we,
    output logic [XLEN-1:0] rdata,
    output logic            m_req,
    input  logic            m_gnt,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    output logic [2:0]      m_we,
    input  logic [XLEN-1:0] m_rdata,
    output logic            irq
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RDW  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;

    localparam logic [1:0] R_SRC  = 2'd0;
    localparam logic [1:0] R_DST  = 2'd1;
    localparam logic [1:0] R_LEN  = 2'd2;
    localparam logic [1:0] R_CTRL = 2'd3;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d;
    logic [LENW-1:0] len_q, len_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            irq_en_q, irq_en_d, abort_q, abort_d;
    logic            m_req_d, irq_d;
    logic [XLEN-1:0] m_addr_d, m_wdata_d;
    logic [2:0]      m_we_d;

    logic reg_wr, wr_open, ctrl_sel;
    logic unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];
    assign reg_wr   = sel && (we != 3'b000);
    assign wr_open  = reg_wr && !busy_q;
    assign ctrl_sel = (addr[3:2] == R_CTRL);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            buf_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            abort_q  <= 1'b0;
            m_req    <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_we     <= 3'b000;
            irq      <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            buf_q    <= buf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            abort_q  <= abort_d;
            m_req    <= m_req_d;
            m_addr   <= m_addr_d;
            m_wdata  <= m_wdata_d;
            m_we     <= m_we_d;
            irq      <= irq_d;
        end
    end

    // Register writes, transfer sequencing and next-cycle master outputs
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        buf_d    = buf_q;
        busy_d   = busy_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;
        abort_d  = abort_q;

        if (wr_open) begin
            case (addr[3:2])
                R_SRC:   src_d = {wdata[XLEN-1:2], 2'b00};
                R_DST:   dst_d = {wdata[XLEN-1:2], 2'b00};
                R_LEN:   len_d = wdata[LENW-1:0];
                default: begin
                    if (wdata[2]) done_d = 1'b0;
                    irq_en_d = wdata[3];
                end
            endcase
        end
        if (reg_wr && ctrl_sel && wdata[4]) abort_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (wr_open && ctrl_sel && wdata[0]) begin
                    if (len_q != '0) begin
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        state_d = S_ARB;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ARB: if (m_gnt) state_d = S_RD;
            S_RD:  state_d = S_RDW;
            S_RDW: begin
                buf_d   = m_rdata;
                state_d = S_WR;
            end
            S_WR: begin
                src_d = src_q + XLEN'(4);
                dst_d = dst_q + XLEN'(4);
                len_d = len_q - LENW'(1);
                if ((len_q == LENW'(1)) || abort_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    abort_d = 1'b0;
                    done_d  = 1'b1;
                end else if (m_gnt) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_ARB;
                end
            end
            default: state_d = S_IDLE;
        endcase

        m_req_d   = (state_d != S_IDLE);
        m_addr_d  = '0;
        m_wdata_d = '0;
        m_we_d    = 3'b000;
        if ((state_d == S_RD) || (state_d == S_RDW)) begin
            m_addr_d = src_d;
        end else if (state_d == S_WR) begin
            m_addr_d  = dst_d;
            m_wdata_d = buf_d;
            m_we_d    = WE_WORD;
        end
        irq_d = done_d & irq_en_d;
    end

    // Combinational register readback
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                R_SRC:   rdata = src_q;
                R_DST:   rdata = dst_q;
                R_LEN:   rdata = XLEN'(len_q);
                default: rdata = XLEN'({abort_q, irq_en_q, done_q, busy_q, 1'b0});
            endcase
        end
    end

endmodule

// File: tb/tb_localbus_dma.sv
// Directed bench for localbus_dma with a behavioural RAM and a write log.
module tb_localbus_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  we;
    logic [31:0] rdata;
    logic        m_req;
    logic        m_gnt;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_we;
    logic [31:0] m_rdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    localbus_dma dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wdata(wdata),
        .we(we), .rdata(rdata), .m_req(m_req), .m_gnt(m_gnt),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
        .m_rdata(m_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // RAM contents: 0xA0.. at 0x1000, inverted address elsewhere
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h1020) return 32'hA0 + ((a - 32'h1000) >> 2);
        return ~a;
    endfunction

    // One-cycle read latency memory and bus write log
    always @(posedge clk) begin
        m_rdata <= mem_rd(m_addr);
        if (m_we != 3'b000) begin
            wr_addr_q.push_back(m_addr);
            wr_data_q.push_back(m_wdata);
            if (m_we !== 3'b011) begin
                failures++;
                $display("FAIL bus_we_code got=%0h exp=3", m_we);
            end
        end
    end

    task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; addr = a; wdata = d; we = 3'b011;
        @(posedge clk); #1;
        sel = 1'b0; we = 3'b000; wdata = '0;
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; addr = a; we = 3'b000;
        #1 d = rdata;
        sel = 1'b0;
    endtask

    // Polls done, counting edges into n; bounded
    task automatic wait_done(inout int n, output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            n++;
            cpu_rd(4'hC, d);
            if (d[2]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0; sel = 1'b0; addr = '0; wdata = '0; we = '0; m_gnt = 1'b0;
        #2;
        checks++;
        if ({m_req, m_addr, m_wdata, m_we, irq} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%0h addr=%0h wdata=%0h we=%0h irq=%0h exp=all 0",
                     m_req, m_addr, m_wdata, m_we, irq);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        cpu_rd(4'hC, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%0h exp=0", d); end
        cpu_rd(4'h0, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_src got=%0h exp=0", d); end
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL rdata_unselected got=%0h exp=0", rdata); end
    endtask

    task automatic test_copy;
        logic [31:0] d;
        int n;
        bit ok;
        wr_addr_q.delete(); wr_data_q.delete();
        m_gnt = 1'b1;
        cpu_wr(4'h0, 32'h0000_1003);
        cpu_wr(4'h4, 32'h0000_2000);
        cpu_wr(4'h8, 32'd4);
        cpu_wr(4'hC, 32'h1);
        n = 0;
        checks++;
        if (m_req !== 1'b1) begin failures++; $display("FAIL copy_req_after_start got=%0h exp=1", m_req); end
        wait_done(n, ok);
        checks++;
        if (!ok || n != 13) begin failures++; $display("FAIL copy_latency got=%0d exp=13", n); end
        checks++;
        if (wr_addr_q.size() != 4) begin
            failures++; $display("FAIL copy_write_count got=%0d exp=4", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr_q[i] !== 32'h2000 + 32'(4 * i) || wr_data_q[i] !== 32'hA0 + 32'(i)) begin
                    failures++;
                    $display("FAIL copy_write%0d got=%0h:%0h exp=%0h:%0h", i, wr_addr_q[i], wr_data_q[i],
                             32'h2000 + 32'(4 * i), 32'hA0 + 32'(i));
                end
            end
        end
        cpu_rd(4'h8, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL copy_len got=%0h exp=0", d); end
        cpu_rd(4'h0, d);
        checks++;
        if (d !== 32'h1010) begin failures++; $display("FAIL copy_src got=%0h exp=1010", d); end
        checks++;
        if (m_req !== 1'b0 || m_we !== 3'b000) begin
            failures++; $display("FAIL copy_idle_bus got req=%0h we=%0h exp=0", m_req, m_we);
        end
    endtask

    task automatic test_grant_withheld;
        logic [31:0] d;
        int n;
        bit ok;
        bit bad;
        wr_addr_q.delete(); wr_data_q.delete();
        m_gnt = 1'b0;
        cpu_wr(4'h0, 32'h1000);
        cpu_wr(4'h4, 32'h3000);
        cpu_wr(4'h8, 32'd1);
        cpu_wr(4'hC, 32'h1);
        n = 0;
        cpu_rd(4'hC, d);
        checks++;
        if (d[2] !== 1'b0 || d[1] !== 1'b1) begin failures++; $display("FAIL start_clears_done got ctrl=%0h exp=2", d); end
        bad = (m_req !== 1'b1) || (m_addr !== 32'h0) || (m_we !== 3'b000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n++;
            if ((m_req !== 1'b1) || (m_addr !== 32'h0) || (m_we !== 3'b000)) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL grant_wait_bus got req=%0h addr=%0h we=%0h exp=1/0/0", m_req, m_addr, m_we); end
        m_gnt = 1'b1;
        wait_done(n, ok);
        checks++;
        if (!ok || n != 9) begin failures++; $display("FAIL grant_latency got=%0d exp=9", n); end
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h3000 || wr_data_q[0] !== 32'hA0) begin
            failures++; $display("FAIL grant_write got count=%0d exp=1 at 3000 data a0", wr_addr_q.size());
        end
    endtask

    task automatic test_len_zero;
        logic [31:0] d;
        bit bad;
        wr_addr_q.delete(); wr_data_q.delete();
        cpu_wr(4'h8, 32'd0);
        cpu_wr(4'hC, 32'h9);
        cpu_rd(4'hC, d);
        checks++;
        if (d !== 32'h0C) begin failures++; $display("FAIL len0_ctrl got=%0h exp=c", d); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL len0_irq got=%0h exp=1", irq); end
        bad = (m_req !== 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (m_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || wr_addr_q.size() != 0) begin failures++; $display("FAIL len0_no_traffic got req=%0h writes=%0d exp=0", m_req, wr_addr_q.size()); end
        cpu_wr(4'hC, 32'h4);
        cpu_rd(4'hC, d);
        checks++;
        if (d[2] !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL done_clear got done=%0h irq=%0h exp=0", d[2], irq); end
    endtask

    task automatic test_abort;
        logic [31:0] d;
        int n;
        bit ok;
        wr_addr_q.delete(); wr_data_q.delete();
        m_gnt = 1'b1;
        cpu_wr(4'h0, 32'h1000);
        cpu_wr(4'h4, 32'h4000);
        cpu_wr(4'h8, 32'd8);
        cpu_wr(4'hC, 32'h1);
        n = 0;
        repeat (4) begin @(posedge clk); #1; n++; end
        cpu_wr(4'hC, 32'h10);
        n++;
        wait_done(n, ok);
        checks++;
        if (!ok || n != 7) begin failures++; $display("FAIL abort_latency got=%0d exp=7", n); end
        checks++;
        if (wr_addr_q.size() != 2 || wr_data_q[1] !== 32'hA1 || wr_addr_q[1] !== 32'h4004) begin
            failures++; $display("FAIL abort_write_count got=%0d exp=2", wr_addr_q.size());
        end
        cpu_rd(4'h8, d);
        checks++;
        if (d !== 32'd6) begin failures++; $display("FAIL abort_len got=%0h exp=6", d); end
        cpu_rd(4'h0, d);
        checks++;
        if (d !== 32'h1008) begin failures++; $display("FAIL abort_src got=%0h exp=1008", d); end
        cpu_rd(4'h4, d);
        checks++;
        if (d !== 32'h4008) begin failures++; $display("FAIL abort_dst got=%0h exp=4008", d); end
        cpu_rd(4'hC, d);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL abort_ctrl got=%0h exp=4", d); end
    endtask

    task automatic test_protect;
        logic [31:0] d;
        int n;
        bit ok;
        wr_addr_q.delete(); wr_data_q.delete();
        m_gnt = 1'b1;
        cpu_wr(4'h0, 32'h1000);
        cpu_wr(4'h4, 32'h5000);
        cpu_wr(4'h8, 32'd2);
        cpu_wr(4'hC, 32'h1);
        n = 0;
        cpu_wr(4'h0, 32'hFFFF_0000); n++;
        cpu_wr(4'hC, 32'h1);         n++;
        cpu_wr(4'h8, 32'd1);         n++;
        wait_done(n, ok);
        checks++;
        if (!ok || n != 7) begin failures++; $display("FAIL protect_latency got=%0d exp=7", n); end
        checks++;
        if (wr_addr_q.size() != 2 || wr_addr_q[1] !== 32'h5004 || wr_data_q[1] !== 32'hA1) begin
            failures++; $display("FAIL protect_writes got=%0d exp=2", wr_addr_q.size());
        end
        cpu_rd(4'h0, d);
        checks++;
        if (d !== 32'h1008) begin failures++; $display("FAIL protect_src got=%0h exp=1008", d); end
        cpu_rd(4'h8, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL protect_len got=%0h exp=0", d); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (m_req !== 1'b0 || wr_addr_q.size() != 2) begin
            failures++; $display("FAIL protect_no_restart got req=%0h writes=%0d exp=0/2", m_req, wr_addr_q.size());
        end
    endtask

    task automatic test_wrap_reset;
        logic [31:0] d;
        bit bad;
        wr_addr_q.delete(); wr_data_q.delete();
        m_gnt = 1'b1;
        cpu_wr(4'h0, 32'hFFFF_FFFC);
        cpu_wr(4'h4, 32'h6000);
        cpu_wr(4'h8, 32'd2);
        cpu_wr(4'hC, 32'h1);
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (m_addr !== 32'h0 || m_req !== 1'b1 || m_we !== 3'b000) begin
            failures++; $display("FAIL wrap_second_read got addr=%0h req=%0h exp=0/1", m_addr, m_req);
        end
        checks++;
        if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'h3) begin
            failures++; $display("FAIL wrap_first_write got count=%0d exp=1 data 3", wr_addr_q.size());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_req, m_addr, m_wdata, m_we, irq} !== '0) begin
            failures++; $display("FAIL async_reset_outputs got req=%0h addr=%0h we=%0h exp=0", m_req, m_addr, m_we);
        end
        #1 rst_n = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (m_req !== 1'b0 || m_we !== 3'b000) bad = 1'b1;
        end
        checks++;
        if (bad || wr_addr_q.size() != 1) begin
            failures++; $display("FAIL reset_no_write got writes=%0d exp=1", wr_addr_q.size());
        end
        cpu_rd(4'h8, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_len got=%0h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_grant_withheld();
        test_len_zero();
        test_abort();
        test_protect();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
